// File: rtl/hs_fifo.sv
// hs_fifo: valid/ready FIFO with first-word fall-through read and any DEPTH >= 2.
// Define HS_FIFO_COUNT_EN to add the occupancy port `count`; otherwise only full/empty flags are kept.
module hs_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
`ifdef HS_FIFO_COUNT_EN
    ,
    output logic [$clog2(DEPTH+1)-1:0] count
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, wr_ptr_nxt;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, rd_ptr_nxt;
    logic             push, pop;

    assign push     = in_valid && in_ready;
    assign pop      = out_valid && out_ready;
    assign out_data = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_nxt = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
        rd_ptr_nxt = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
        wr_ptr_d   = push ? wr_ptr_nxt : wr_ptr_q;
        rd_ptr_d   = pop  ? rd_ptr_nxt : rd_ptr_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage is not reset; the pointers alone decide which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

`ifdef HS_FIFO_COUNT_EN
    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign in_ready  = (count_q != CNT_W'(DEPTH));
    assign out_valid = (count_q != '0);
    assign count     = count_q;
`else
    logic full_q, full_d;
    logic empty_q, empty_d;

    // Pointers are equal both when full and when empty; the flags disambiguate.
    always_comb begin
        full_d  = full_q;
        empty_d = empty_q;
        case ({push, pop})
            2'b10: begin
                empty_d = 1'b0;
                full_d  = (wr_ptr_nxt == rd_ptr_q);
            end
            2'b01: begin
                full_d  = 1'b0;
                empty_d = (rd_ptr_nxt == wr_ptr_q);
            end
            default: begin
                full_d  = full_q;
                empty_d = empty_q;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            full_q  <= full_d;
            empty_q <= empty_d;
        end
    end

    assign in_ready  = !full_q;
    assign out_valid = !empty_q;
`endif

endmodule

// File: tb/tb_hs_fifo.sv
// Directed-vector and random-traffic bench for hs_fifo at WIDTH=8, DEPTH=4.
module tb_hs_fifo;
    localparam int WIDTH = 8;
    localparam int DEPTH = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
`ifdef HS_FIFO_COUNT_EN
    logic [2:0]       count;
`endif

    hs_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef HS_FIFO_COUNT_EN
        ,
        .count     (count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       iv;
        logic [7:0] id;
        logic       orr;
        logic       ir;
        logic       ov;
        logic [7:0] od;
        logic [2:0] cnt;
    } vec_t;

    vec_t       vecs[$];
    int         total = 0;
    int         passed = 0;
    logic [7:0] model_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            passed++;
        end
    endtask

    task automatic step(input logic iv, input logic [7:0] id, input logic orr);
        in_valid  = iv;
        in_data   = id;
        out_ready = orr;
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic iv, input logic [7:0] id, input logic orr,
                       input logic ir, input logic ov, input logic [7:0] od, input logic [2:0] cnt);
        vecs.push_back('{iv, id, orr, ir, ov, od, cnt});
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;

        // Fill to full, then pop with a blocked push.
        add(1, 8'h11, 0, 1, 1, 8'h11, 1);
        add(1, 8'h22, 0, 1, 1, 8'h11, 2);
        add(1, 8'h33, 0, 1, 1, 8'h11, 3);
        add(1, 8'h44, 0, 0, 1, 8'h11, 4);
        add(1, 8'h55, 1, 1, 1, 8'h22, 3);
        add(0, 8'h00, 1, 1, 1, 8'h33, 2);
        add(0, 8'h00, 1, 1, 1, 8'h44, 1);
        add(0, 8'h00, 1, 1, 0, 8'h00, 0);
        // Push into empty with out_ready held: no same-cycle bypass.
        add(1, 8'hA5, 1, 1, 1, 8'hA5, 1);
        add(0, 8'h00, 1, 1, 0, 8'h00, 0);
        // Preload two words, then ten push+pop cycles across pointer wraps.
        add(1, 8'hE0, 0, 1, 1, 8'hE0, 1);
        add(1, 8'hE1, 0, 1, 1, 8'hE0, 2);
        add(1, 8'h00, 1, 1, 1, 8'hE1, 2);
        for (int k = 1; k < 10; k++) begin
            add(1, 8'(k), 1, 1, 1, 8'(k - 1), 2);
        end
        add(0, 8'h00, 1, 1, 1, 8'h09, 1);
        add(0, 8'h00, 1, 1, 0, 8'h00, 0);

        repeat (2) @(posedge clk);
        #1;
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_out_valid", 32'(out_valid), 32'd0);
`ifdef HS_FIFO_COUNT_EN
        check("reset_count", 32'(count), 32'd0);
`endif
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            step(vecs[i].iv, vecs[i].id, vecs[i].orr);
            check($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].ir));
            check($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].ov));
            if (vecs[i].ov) begin
                check($sformatf("vec%0d_out_data", i), 32'(out_data), 32'(vecs[i].od));
            end
`ifdef HS_FIFO_COUNT_EN
            check($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].cnt));
`endif
        end

        // Mid-stream asynchronous reset with three words stored.
        step(1, 8'h01, 0);
        step(1, 8'h02, 0);
        step(1, 8'h03, 0);
        in_valid = 1'b0;
        check("pre_rst_out_data", 32'(out_data), 32'h01);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_out_valid", 32'(out_valid), 32'd0);
        check("async_rst_in_ready", 32'(in_ready), 32'd1);
`ifdef HS_FIFO_COUNT_EN
        check("async_rst_count", 32'(count), 32'd0);
`endif
        #1;
        rst_n = 1'b1;
        step(0, 8'h00, 0);
        check("post_rst_empty", 32'(out_valid), 32'd0);
        step(1, 8'h7E, 0);
        check("post_rst_out_valid", 32'(out_valid), 32'd1);
        check("post_rst_first_word", 32'(out_data), 32'h7E);
        step(1, 8'h7F, 1);
        check("post_rst_second_word", 32'(out_data), 32'h7F);
        step(0, 8'h00, 1);
        check("post_rst_drained", 32'(out_valid), 32'd0);
        step(0, 8'h00, 0);

        // Random traffic against a reference queue.
        model_q.delete();
        for (int c = 0; c < 10000; c++) begin
            logic       iv, orr, do_push, do_pop;
            logic [7:0] id;
            iv  = 1'($urandom_range(0, 1));
            orr = 1'($urandom_range(0, 1));
            id  = 8'($urandom);
            in_valid  = iv;
            in_data   = id;
            out_ready = orr;
            #1;
            check("rand_in_ready", 32'(in_ready), 32'(model_q.size() != DEPTH));
            check("rand_out_valid", 32'(out_valid), 32'(model_q.size() != 0));
            if (model_q.size() != 0) begin
                check("rand_out_data", 32'(out_data), 32'(model_q[0]));
            end
`ifdef HS_FIFO_COUNT_EN
            check("rand_count", 32'(count), 32'(model_q.size()));
`endif
            do_push = iv && (model_q.size() != DEPTH);
            do_pop  = orr && (model_q.size() != 0);
            @(posedge clk);
            if (do_pop) begin
                void'(model_q.pop_front());
            end
            if (do_push) begin
                model_q.push_back(id);
            end
            #1;
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
